// File: rtl/incr_arbiter.sv
// incr_arbiter: round-robin, burst-limited sharing of one +1 incrementer among NREQ requesters
module incr_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 40,
  parameter int BURST = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [W-1:0]              rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  input  logic                      rsp_ready,
  output logic [15:0]               txn_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, win, idx;
  logic [BW-1:0] burst_cnt;
  logic can_accept, accept, keep;
  // winner: continue an active burst, else scan from ptr+1 with ptr checked last
  always_comb begin
    idx = '0;
    win = ptr;
    keep = req_valid[ptr] && burst_cnt != '0 && burst_cnt < BW'(BURST);
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) win = idx;
    end
    if (keep) win = ptr;
  end
  // handshake and EMPTY/FULL next state; no grant while reset is asserted
  always_comb begin
    can_accept = state == EMPTY || rsp_ready;
    accept = !reset && can_accept && |req_valid;
    req_ready = accept ? NREQ'(1) << win : '0;
    state_nx = accept ? FULL : (rsp_ready ? EMPTY : state);
  end
  assign rsp_valid = state == FULL;
  // result register, arbitration pointer, burst count and transaction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      ptr <= IW'(NREQ - 1);
      burst_cnt <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
      txn_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rsp_data <= req_data[win*W +: W] + W'(1);
        rsp_id <= win;
        txn_cnt <= txn_cnt + 16'd1;
        if (win == ptr) burst_cnt <= burst_cnt == BW'(BURST) ? BW'(1) : burst_cnt + BW'(1);
        else begin
          ptr <= win;
          burst_cnt <= BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_incr_arbiter.sv
// tb_incr_arbiter: table-driven directed check of incr_arbiter grants, results and counters
module tb_incr_arbiter;
  logic clk = 0, reset = 1, rsp_ready = 0, rsp_valid;
  logic [3:0] req_valid = 0, req_ready;
  logic [159:0] req_data = 0;
  logic [39:0] rsp_data;
  logic [1:0] rsp_id;
  logic [15:0] txn_cnt;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [39:0] d;
    logic rr;
    logic [3:0] erdy;
    logic erv;
    logic [39:0] erd;
    logic [1:0] eid;
    logic [15:0] ecnt;
  } vec_t;
  vec_t tbl [34];
  incr_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .txn_cnt(txn_cnt)
  );
  always #5 clk = ~clk;
  // requester i sees operand d + i*256
  task automatic drive(input logic r, input logic [3:0] v, input logic [39:0] d, input logic rr);
    @(negedge clk);
    reset = r;
    req_valid = v;
    req_data = {d + 40'h300, d + 40'h200, d + 40'h100, d};
    rsp_ready = rr;
    #1;
  endtask
  task automatic check(input string tag, input logic [3:0] erdy, input logic erv,
                       input logic [39:0] erd, input logic [1:0] eid, input logic [15:0] ecnt);
    logic bad;
    bad = 0;
    nvec++;
    if (req_ready !== erdy) begin bad = 1; $display("FAIL %s req_ready got %b want %b", tag, req_ready, erdy); end
    if (rsp_valid !== erv) begin bad = 1; $display("FAIL %s rsp_valid got %b want %b", tag, rsp_valid, erv); end
    if (rsp_data !== erd) begin bad = 1; $display("FAIL %s rsp_data got %h want %h", tag, rsp_data, erd); end
    if (rsp_id !== eid) begin bad = 1; $display("FAIL %s rsp_id got %0d want %0d", tag, rsp_id, eid); end
    if (txn_cnt !== ecnt) begin bad = 1; $display("FAIL %s txn_cnt got %0d want %0d", tag, txn_cnt, ecnt); end
    if (bad) nerr++;
  endtask
  initial begin
    tbl[0]  = '{1, 4'b1111, 40'h0,          1, 4'b0000, 0, 40'h0,      0, 16'd0};
    tbl[1]  = '{0, 4'b0001, 40'h5,          1, 4'b0001, 0, 40'h0,      0, 16'd0};
    tbl[2]  = '{0, 4'b0000, 40'h5,          1, 4'b0000, 1, 40'h6,      0, 16'd1};
    tbl[3]  = '{0, 4'b0010, 40'hFF_FFFF_FEFF, 1, 4'b0010, 0, 40'h6,    0, 16'd1};
    tbl[4]  = '{0, 4'b0000, 40'h0,          1, 4'b0000, 1, 40'h0,      1, 16'd2};
    tbl[5]  = '{1, 4'b1111, 40'h1000,       1, 4'b0000, 0, 40'h0,      1, 16'd2};
    tbl[6]  = '{0, 4'b1111, 40'h1000,       1, 4'b0001, 0, 40'h0,      0, 16'd0};
    tbl[7]  = '{0, 4'b1111, 40'h1000,       1, 4'b0001, 1, 40'h1001,   0, 16'd1};
    tbl[8]  = '{0, 4'b1111, 40'h1000,       1, 4'b0010, 1, 40'h1001,   0, 16'd2};
    tbl[9]  = '{0, 4'b1111, 40'h1000,       1, 4'b0010, 1, 40'h1101,   1, 16'd3};
    tbl[10] = '{0, 4'b1111, 40'h1000,       1, 4'b0100, 1, 40'h1101,   1, 16'd4};
    tbl[11] = '{0, 4'b1111, 40'h1000,       1, 4'b0100, 1, 40'h1201,   2, 16'd5};
    tbl[12] = '{0, 4'b1111, 40'h1000,       1, 4'b1000, 1, 40'h1201,   2, 16'd6};
    tbl[13] = '{0, 4'b1111, 40'h1000,       1, 4'b1000, 1, 40'h1301,   3, 16'd7};
    tbl[14] = '{0, 4'b1111, 40'h1000,       1, 4'b0001, 1, 40'h1301,   3, 16'd8};
    tbl[15] = '{0, 4'b1111, 40'h1000,       1, 4'b0001, 1, 40'h1001,   0, 16'd9};
    tbl[16] = '{0, 4'b1111, 40'h1000,       1, 4'b0010, 1, 40'h1001,   0, 16'd10};
    tbl[17] = '{0, 4'b1111, 40'h1000,       1, 4'b0010, 1, 40'h1101,   1, 16'd11};
    tbl[18] = '{0, 4'b1111, 40'h1000,       1, 4'b0100, 1, 40'h1101,   1, 16'd12};
    tbl[19] = '{0, 4'b1111, 40'h1000,       0, 4'b0000, 1, 40'h1201,   2, 16'd13};
    tbl[20] = '{0, 4'b1111, 40'h1000,       0, 4'b0000, 1, 40'h1201,   2, 16'd13};
    tbl[21] = '{0, 4'b1111, 40'h1000,       0, 4'b0000, 1, 40'h1201,   2, 16'd13};
    tbl[22] = '{0, 4'b1111, 40'h1000,       1, 4'b0100, 1, 40'h1201,   2, 16'd13};
    tbl[23] = '{0, 4'b1111, 40'h1000,       1, 4'b1000, 1, 40'h1201,   2, 16'd14};
    tbl[24] = '{0, 4'b1000, 40'h2000,       1, 4'b1000, 1, 40'h1301,   3, 16'd15};
    tbl[25] = '{0, 4'b1000, 40'h2000,       1, 4'b1000, 1, 40'h2301,   3, 16'd16};
    tbl[26] = '{0, 4'b1000, 40'h2000,       1, 4'b1000, 1, 40'h2301,   3, 16'd17};
    tbl[27] = '{0, 4'b1000, 40'h2000,       1, 4'b1000, 1, 40'h2301,   3, 16'd18};
    tbl[28] = '{0, 4'b1000, 40'h2000,       1, 4'b1000, 1, 40'h2301,   3, 16'd19};
    tbl[29] = '{0, 4'b0000, 40'h2000,       0, 4'b0000, 1, 40'h2301,   3, 16'd20};
    tbl[30] = '{1, 4'b1111, 40'h3000,       0, 4'b0000, 1, 40'h2301,   3, 16'd20};
    tbl[31] = '{0, 4'b1111, 40'h3000,       1, 4'b0001, 0, 40'h0,      0, 16'd0};
    tbl[32] = '{0, 4'b0000, 40'h3000,       1, 4'b0000, 1, 40'h3001,   0, 16'd1};
    tbl[33] = '{0, 4'b0000, 40'h3000,       0, 4'b0000, 0, 40'h3001,   0, 16'd1};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rr);
      check($sformatf("vec%0d", i), tbl[i].erdy, tbl[i].erv, tbl[i].erd, tbl[i].eid, tbl[i].ecnt);
    end
    drive(0, 4'b0100, 40'h4000, 0);
    check("empty_accept_no_rsp_ready", 4'b0100, 0, 40'h3001, 0, 16'd1);
    drive(0, 4'b0100, 40'h4000, 0);
    check("full_stall", 4'b0000, 1, 40'h4201, 2, 16'd2);
    drive(0, 4'b0100, 40'h5000, 1);
    check("burst_continue", 4'b0100, 1, 40'h4201, 2, 16'd2);
    drive(0, 4'b0101, 40'h5000, 1);
    check("burst_limit_rotate", 4'b0001, 1, 40'h5201, 2, 16'd3);
    drive(0, 4'b0000, 40'h0, 1);
    check("rotate_result", 4'b0000, 1, 40'h5001, 0, 16'd4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
